sti_rx_deser: RTL and testbench

//  Serial receive stage fed by the STI transmitter's so_data/so_valid pair.
//  - Rebuilds 8/16/24/32-bit words from the bit stream.
//  - Buffers finished words in a small first-word-fall-through (FWFT) FIFO.
//  - Presents words on a valid/ready port to the DAC/memory-write logic or to a checker.
//  - Also serves as the loop-back monitor for transmitter bring-up.

---
 rtl/sti_rx_deser.sv | 150 +++++++++++++++
 tb/tb_sti_rx_deser.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sti_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module      : sti_rx_deser
//  Description : STI serial receive stage: rebuilds 8/16/24/32-bit words from
//                the bit stream and queues them in a FWFT FIFO behind a
//                valid/ready port. Optional STI_RX_WORD_CNT_EN adds rx_word_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module sti_rx_deser #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_msb,
    input  logic        si_data,
    input  logic        si_valid,
    output logic [31:0] rx_data,
    output logic [1:0]  rx_len,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        ovf
`ifdef STI_RX_WORD_CNT_EN
    ,
    output logic [15:0] rx_word_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_len;
    logic        r_msb;
    logic [4:0]  r_bit_cnt;
    logic [4:0]  w_bit_cnt_nxt;
    logic [31:0] r_shreg;

    logic        w_start;
    logic [1:0]  w_len;
    logic        w_msb;
    logic [4:0]  w_k;
    logic [31:0] w_base;
    logic [31:0] w_word;
    logic        w_done;
    logic        w_ferr;

    logic [33:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    // On the first bit of a word the live cfg inputs are used, afterwards the latched copy.
    always_comb begin
        w_start       = (r_state == IDLE) && si_valid;
        w_len         = w_start ? cfg_length : r_len;
        w_msb         = w_start ? cfg_msb : r_msb;
        w_k           = w_start ? 5'd0 : r_bit_cnt;
        w_base        = w_start ? 32'd0 : r_shreg;
        w_word        = w_msb ? {w_base[30:0], si_data}
                              : (w_base | (32'(si_data) << w_k));
        w_done        = si_valid && (w_k == {w_len, 3'b111});
        w_ferr        = (r_state == SHIFT) && !si_valid;
        w_state_nxt   = IDLE;
        w_bit_cnt_nxt = 5'd0;
        if (si_valid && !w_done) begin
            w_state_nxt   = SHIFT;
            w_bit_cnt_nxt = w_k + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_len     <= 2'd0;
            r_msb     <= 1'b0;
            r_bit_cnt <= 5'd0;
            r_shreg   <= 32'd0;
            frame_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            frame_err <= w_ferr;
            r_shreg   <= si_valid ? w_word : 32'd0;
            if (w_start) begin
                r_len <= cfg_length;
                r_msb <= cfg_msb;
            end
        end
    end

    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
    assign rx_valid = (r_count != '0);
    assign w_pop    = rx_valid && rx_ready;
    assign w_push   = w_done && (!w_full || w_pop);
    assign rx_data  = rx_valid ? r_mem[r_rd][31:0]  : 32'd0;
    assign rx_len   = rx_valid ? r_mem[r_rd][33:32] : 2'd0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= {w_len, w_word};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            ovf     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
            if (w_done && !w_push) begin
                ovf <= 1'b1;
            end
        end
    end

`ifdef STI_RX_WORD_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_word_cnt <= 16'd0;
        end else if (w_push) begin
            rx_word_cnt <= rx_word_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sti_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sti_rx_deser
//  Description : Directed self-checking bench for sti_rx_deser.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sti_rx_deser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cfg_length = 2'd0;
    logic        cfg_msb = 1'b0;
    logic        si_data = 1'b0;
    logic        si_valid = 1'b0;
    logic [31:0] rx_data;
    logic [1:0]  rx_len;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        frame_err;
    logic        ovf;
`ifdef STI_RX_WORD_CNT_EN
    logic [15:0] rx_word_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;
    int fe_cnt  = 0;
    int fe_ref;

    sti_rx_deser #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_length (cfg_length),
        .cfg_msb    (cfg_msb),
        .si_data    (si_data),
        .si_valid   (si_valid),
        .rx_data    (rx_data),
        .rx_len     (rx_len),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .ovf        (ovf)
`ifdef STI_RX_WORD_CNT_EN
        ,
        .rx_word_cnt(rx_word_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives bits first..last of a word; cfg is only correct on bit 0 so later
    // cycles present the opposite setting, which the DUT must ignore.
    task automatic send_bits(input logic [31:0] val, input logic [1:0] len,
                             input logic msb, input int first, input int last);
        int n;
        n = 8 * (int'(len) + 1);
        for (int k = first; k <= last; k++) begin
            si_valid = 1'b1;
            si_data  = msb ? val[n-1-k] : val[k];
            if (k == 0) begin
                cfg_length = len;
                cfg_msb    = msb;
            end else begin
                cfg_length = ~len;
                cfg_msb    = ~msb;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        si_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_len);
        chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        chk({tag, "_data"}, rx_data, exp_data);
        chk({tag, "_len"}, {30'd0, rx_len}, {30'd0, exp_len});
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", rx_data, 32'd0);
        chk("rst_len", {30'd0, rx_len}, 32'd0);
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        reset = 1'b0;
        idle(2);

        // 1: 8-bit MSB-first A5, valid exactly one cycle after the 8th sample
        send_bits(32'hA5, 2'd0, 1'b1, 0, 6);
        chk("t1_early_valid", {31'd0, rx_valid}, 32'd0);
        send_bits(32'hA5, 2'd0, 1'b1, 7, 7);
        chk("t1_latency", {31'd0, rx_valid}, 32'd1);
        idle(1);
        pop_chk("t1", 32'h000000A5, 2'd0);
        chk("t1_empty", {31'd0, rx_valid}, 32'd0);

        // Empty-FIFO pop attempts are ignored
        rx_ready = 1'b1;
        idle(2);
        rx_ready = 1'b0;

        // 2: 16-bit LSB-first 1234
        send_bits(32'h1234, 2'd1, 1'b0, 0, 15);
        idle(1);
        pop_chk("t2", 32'h00001234, 2'd1);

        // 3: back-to-back 24-bit then 32-bit, no gap
        fe_ref = fe_cnt;
        send_bits(32'hABCDEF, 2'd2, 1'b1, 0, 23);
        send_bits(32'hDEADBEEF, 2'd3, 1'b1, 0, 31);
        idle(2);
        chk("t3_no_ferr", fe_cnt - fe_ref, 32'd0);
        pop_chk("t3a", 32'h00ABCDEF, 2'd2);
        pop_chk("t3b", 32'hDEADBEEF, 2'd3);

        // 4: abort after bit 9 of a 16-bit word
        fe_ref = fe_cnt;
        send_bits(32'hFFFF, 2'd1, 1'b1, 0, 9);
        idle(3);
        chk("t4_ferr_once", fe_cnt - fe_ref, 32'd1);
        chk("t4_no_push", {31'd0, rx_valid}, 32'd0);
        send_bits(32'hC3A5, 2'd1, 1'b0, 0, 15);
        idle(1);
        pop_chk("t4", 32'h0000C3A5, 2'd1);

        // 5: overflow with depth 4
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("t5_ovf_pre", {31'd0, ovf}, 32'd0);
            send_bits(32'h11 * (i + 1), 2'd0, 1'b1, 0, 7);
            idle(1);
        end
        chk("t5_ovf", {31'd0, ovf}, 32'd1);
        chk("t5_head_stable", rx_data, 32'h11);
        for (int i = 0; i < 4; i++) begin
            pop_chk("t5_pop", 32'h11 * (i + 1), 2'd0);
        end
        chk("t5_drained", {31'd0, rx_valid}, 32'd0);
        chk("t5_ovf_sticky", {31'd0, ovf}, 32'd1);

        // 6: reset mid-word with two words queued
        send_bits(32'h5A, 2'd0, 1'b1, 0, 7);
        send_bits(32'h6B, 2'd0, 1'b1, 0, 7);
        send_bits(32'h12345678, 2'd3, 1'b0, 0, 11);
        si_valid = 1'b0;
        reset    = 1'b1;
        #2;
        chk("t6_valid", {31'd0, rx_valid}, 32'd0);
        chk("t6_ovf", {31'd0, ovf}, 32'd0);
        @(posedge clk); #3;
        reset = 1'b0;
        fe_ref = fe_cnt;
        idle(2);
        chk("t6_no_ferr", fe_cnt - fe_ref, 32'd0);
        send_bits(32'h89ABCDEF, 2'd3, 1'b0, 0, 31);
        idle(1);
`ifdef STI_RX_WORD_CNT_EN
        chk("t6_wcnt", {16'd0, rx_word_cnt}, 32'd1);
`endif
        pop_chk("t6", 32'h89ABCDEF, 2'd3);
        chk("t6_empty", {31'd0, rx_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
